// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS EX stage: ALUOp codes, funct codes,
// ALU control enum, multiply FSM state codes and the ALU control decoder.
package mips_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   // Multiply sequencing states (kept as plain codes for older tools)
   localparam logic [1:0] MS_IDLE = 2'd0;
   localparam logic [1:0] MS_MUL  = 2'd1;
   localparam logic [1:0] MS_DONE = 2'd2;

   // Width of the multiplier step counter (enough for 32 steps)
   localparam int MUL_CNT_W = 6;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_MFHI, ALU_MFLO, ALU_MULT, ALU_MULTU, ALU_NONE
   } alu_ctrl_t;

   // Map ALUOp and funct to one ALU operation; unknown funct yields ALU_NONE
   function automatic alu_ctrl_t alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
      alu_ctrl_t ctrl;
      ctrl = ALU_NONE;
      case (alu_op)
         ALUOP_ADD: ctrl = ALU_ADD;
         ALUOP_SUB: ctrl = ALU_SUB;
         ALUOP_OR:  ctrl = ALU_OR;
         ALUOP_RTYPE: begin
            case (funct)
               FN_ADD, FN_ADDU: ctrl = ALU_ADD;
               FN_SUB, FN_SUBU: ctrl = ALU_SUB;
               FN_AND:          ctrl = ALU_AND;
               FN_OR:           ctrl = ALU_OR;
               FN_XOR:          ctrl = ALU_XOR;
               FN_NOR:          ctrl = ALU_NOR;
               FN_SLT:          ctrl = ALU_SLT;
               FN_SLTU:         ctrl = ALU_SLTU;
               FN_SLL:          ctrl = ALU_SLL;
               FN_SRL:          ctrl = ALU_SRL;
               FN_SRA:          ctrl = ALU_SRA;
               FN_MFHI:         ctrl = ALU_MFHI;
               FN_MFLO:         ctrl = ALU_MFLO;
               FN_MULT:         ctrl = ALU_MULT;
               FN_MULTU:        ctrl = ALU_MULTU;
               default:         ctrl = ALU_NONE;
            endcase
         end
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/mult_seq.sv
// Iterative shift-add multiplier. Signed operands are converted to
// magnitudes on start and the final product is negated when the signs differ.
// done pulses during the last step and product is valid in that same cycle.
module mult_seq
   import mips_pkg::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [63:0] product
);

   logic [63:0]          mcand;
   logic [63:0]          acc;
   logic [63:0]          acc_next;
   logic [31:0]          mplier;
   logic [31:0]          a_mag;
   logic [31:0]          b_mag;
   logic                 neg;
   logic [MUL_CNT_W-1:0] count;

   assign a_mag    = (is_signed && a[31]) ? (~a + 32'd1) : a;
   assign b_mag    = (is_signed && b[31]) ? (~b + 32'd1) : b;
   assign acc_next = mplier[0] ? (acc + mcand) : acc;
   assign done     = busy && (count == MUL_CNT_W'(MUL_CYCLES - 1));
   assign product  = neg ? (~acc_next + 64'd1) : acc_next;

   // Load operands on start, then one shift-add step per cycle while busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= 1'b0;
         neg    <= 1'b0;
         count  <= '0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
      end else if (start && !busy) begin
         busy   <= 1'b1;
         neg    <= is_signed && (a[31] ^ b[31]);
         count  <= '0;
         mcand  <= {32'd0, a_mag};
         mplier <= b_mag;
         acc    <= '0;
      end else if (busy) begin
         acc    <= acc_next;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/ex_stage.sv
// EX stage of the 5-stage MIPS pipeline: ALU control decode, ALU, RegDst mux
// and the EX/MEM pipeline register.
// Optional feature macro EX_MULT_EN: adds the iterative multiplier, HI/LO and
// the multiply FSM that stalls upstream stages. Without it, mult/multu act as
// unknown functs and mfhi/mflo return 0.
module ex_stage
   import mips_pkg::*;
#(
   parameter int MUL_CYCLES = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  ALUOp,
   input  logic        RegWrite,
   input  logic        RegDst,
   input  logic        ALUSrc,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic        MemtoReg,
   input  logic [31:0] RsData,
   input  logic [31:0] RtData,
   input  logic [31:0] SignImm,
   input  logic [4:0]  RtAddr,
   input  logic [4:0]  RdAddr,
   output logic        stall_o,
   output logic        RegWriteOut,
   output logic        MemWriteOut,
   output logic        MemReadOut,
   output logic        MemtoRegOut,
   output logic [31:0] ALUResultOut,
   output logic [31:0] WriteDataOut,
   output logic [4:0]  WriteRegOut
);

   logic [31:0] op_b;
   logic [4:0]  shamt;
   alu_ctrl_t   alu_ctrl;
   logic [31:0] alu_result;
   logic [31:0] hi_val;
   logic [31:0] lo_val;
   logic        bubble;

   assign op_b     = ALUSrc ? SignImm : RtData;
   assign shamt    = SignImm[10:6];
   assign alu_ctrl = alu_decode(ALUOp, SignImm[5:0]);

   if (MUL_CYCLES < 1 || MUL_CYCLES > 32) begin : g_bad_mul_cycles
      $error("ex_stage: MUL_CYCLES must be in 1..32");
   end

`ifdef EX_MULT_EN
   logic [1:0]  state;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic        is_mult;
   logic        mul_start;
   logic        mul_busy;
   logic        mul_done;
   logic [63:0] mul_product;

   assign is_mult   = (alu_ctrl == ALU_MULT) || (alu_ctrl == ALU_MULTU);
   assign mul_start = (state == MS_IDLE) && is_mult;
   assign bubble    = (state != MS_IDLE) || is_mult;
   assign stall_o   = rst_n && (mul_busy || mul_start);
   assign hi_val    = hi_q;
   assign lo_val    = lo_q;

   mult_seq #(
      .MUL_CYCLES(MUL_CYCLES)
   ) u_mult (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (mul_start),
      .is_signed(alu_ctrl == ALU_MULT),
      .a        (RsData),
      .b        (RtData),
      .busy     (mul_busy),
      .done     (mul_done),
      .product  (mul_product)
   );

   // Multiply sequencing: IDLE -> MUL until the last step writes HI/LO -> DONE drains the held mult
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MS_IDLE;
         hi_q  <= '0;
         lo_q  <= '0;
      end else begin
         case (state)
            MS_IDLE: begin
               if (mul_start) begin
                  state <= MS_MUL;
               end
            end
            MS_MUL: begin
               if (mul_done) begin
                  state <= MS_DONE;
                  hi_q  <= mul_product[63:32];
                  lo_q  <= mul_product[31:0];
               end
            end
            MS_DONE: state <= MS_IDLE;
            default: state <= MS_IDLE;
         endcase
      end
   end
`else
   assign bubble  = 1'b0;
   assign stall_o = 1'b0;
   assign hi_val  = '0;
   assign lo_val  = '0;
`endif

   // ALU datapath selected by the decoded control
   always_comb begin
      alu_result = '0;
      case (alu_ctrl)
         ALU_ADD:  alu_result = RsData + op_b;
         ALU_SUB:  alu_result = RsData - op_b;
         ALU_AND:  alu_result = RsData & op_b;
         ALU_OR:   alu_result = RsData | op_b;
         ALU_XOR:  alu_result = RsData ^ op_b;
         ALU_NOR:  alu_result = ~(RsData | op_b);
         ALU_SLT:  alu_result = {31'd0, $signed(RsData) < $signed(op_b)};
         ALU_SLTU: alu_result = {31'd0, RsData < op_b};
         ALU_SLL:  alu_result = op_b << shamt;
         ALU_SRL:  alu_result = op_b >> shamt;
         ALU_SRA:  alu_result = $signed(op_b) >>> shamt;
         ALU_MFHI: alu_result = hi_val;
         ALU_MFLO: alu_result = lo_val;
         default:  alu_result = '0;
      endcase
   end

   // EX/MEM register; a bubble clears the control bits and zeroes the data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWriteOut  <= 1'b0;
         MemWriteOut  <= 1'b0;
         MemReadOut   <= 1'b0;
         MemtoRegOut  <= 1'b0;
         ALUResultOut <= '0;
         WriteDataOut <= '0;
         WriteRegOut  <= '0;
      end else begin
         RegWriteOut  <= RegWrite && !bubble;
         MemWriteOut  <= MemWrite && !bubble;
         MemReadOut   <= MemRead && !bubble;
         MemtoRegOut  <= MemtoReg && !bubble;
         ALUResultOut <= bubble ? 32'd0 : alu_result;
         WriteDataOut <= bubble ? 32'd0 : RtData;
         WriteRegOut  <= bubble ? 5'd0 : (RegDst ? RdAddr : RtAddr);
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage. Expected EX/MEM contents are pushed to a
// scoreboard queue when an instruction is driven and popped when the
// registered outputs appear one cycle later. Handles both EX_MULT_EN builds.
module tb_ex_stage;

   localparam int MC = 32;

   typedef struct packed {
      logic [1:0]  aluop;
      logic        regwrite;
      logic        regdst;
      logic        alusrc;
      logic        memwrite;
      logic        memread;
      logic        memtoreg;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  rt_addr;
      logic [4:0]  rd_addr;
   } ex_in_t;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] result;
      logic [31:0] wdata;
      logic [4:0]  wreg;
   } ex_out_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  ALUOp;
   logic        RegWrite, RegDst, ALUSrc, MemWrite, MemRead, MemtoReg;
   logic [31:0] RsData, RtData, SignImm;
   logic [4:0]  RtAddr, RdAddr;
   logic        stall_o;
   logic        RegWriteOut, MemWriteOut, MemReadOut, MemtoRegOut;
   logic [31:0] ALUResultOut, WriteDataOut;
   logic [4:0]  WriteRegOut;

   int          n_compared = 0;
   int          n_mismatched = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   ex_out_t     exp_q[$];

   localparam ex_out_t BUBBLE = '0;

   ex_stage #(
      .MUL_CYCLES(MC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ALUOp       (ALUOp),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .ALUSrc      (ALUSrc),
      .MemWrite    (MemWrite),
      .MemRead     (MemRead),
      .MemtoReg    (MemtoReg),
      .RsData      (RsData),
      .RtData      (RtData),
      .SignImm     (SignImm),
      .RtAddr      (RtAddr),
      .RdAddr      (RdAddr),
      .stall_o     (stall_o),
      .RegWriteOut (RegWriteOut),
      .MemWriteOut (MemWriteOut),
      .MemReadOut  (MemReadOut),
      .MemtoRegOut (MemtoRegOut),
      .ALUResultOut(ALUResultOut),
      .WriteDataOut(WriteDataOut),
      .WriteRegOut (WriteRegOut)
   );

   // Free-running pipeline clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input ex_in_t in);
      ALUOp    = in.aluop;
      RegWrite = in.regwrite;
      RegDst   = in.regdst;
      ALUSrc   = in.alusrc;
      MemWrite = in.memwrite;
      MemRead  = in.memread;
      MemtoReg = in.memtoreg;
      RsData   = in.rs;
      RtData   = in.rt;
      SignImm  = in.imm;
      RtAddr   = in.rt_addr;
      RdAddr   = in.rd_addr;
   endtask

   task automatic check_ex_mem(input string tag, input ex_out_t e);
      checkOutput({tag, ".ctrl"},
                  {28'd0, RegWriteOut, MemWriteOut, MemReadOut, MemtoRegOut}, {28'd0, e.ctrl});
      checkOutput({tag, ".result"}, ALUResultOut, e.result);
      checkOutput({tag, ".wdata"}, WriteDataOut, e.wdata);
      checkOutput({tag, ".wreg"}, {27'd0, WriteRegOut}, {27'd0, e.wreg});
   endtask

   function automatic ex_out_t mk_out(input logic [3:0] ctrl, input logic [31:0] result,
                                      input logic [31:0] wdata, input logic [4:0] wreg);
      ex_out_t o;
      o.ctrl   = ctrl;
      o.result = result;
      o.wdata  = wdata;
      o.wreg   = wreg;
      return o;
   endfunction

   function automatic ex_in_t rtype(input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                                    input logic [4:0] rd, input logic [4:0] sh);
      ex_in_t in;
      in          = '0;
      in.aluop    = 2'b10;
      in.regwrite = 1'b1;
      in.regdst   = 1'b1;
      in.rs       = rs;
      in.rt       = rt;
      in.imm      = {21'd0, sh, fn};
      in.rt_addr  = 5'd30;
      in.rd_addr  = rd;
      return in;
   endfunction

   // Reference behaviour of one non-multiply instruction
   function automatic ex_out_t model(input ex_in_t in);
      logic [31:0] b;
      logic [31:0] r;
      logic [4:0]  sh;
      ex_out_t     o;
      b  = in.alusrc ? in.imm : in.rt;
      sh = in.imm[10:6];
      r  = 32'd0;
      case (in.aluop)
         2'b00: r = in.rs + b;
         2'b01: r = in.rs - b;
         2'b11: r = in.rs | b;
         default: begin
            case (in.imm[5:0])
               6'h20, 6'h21: r = in.rs + b;
               6'h22, 6'h23: r = in.rs - b;
               6'h24: r = in.rs & b;
               6'h25: r = in.rs | b;
               6'h26: r = in.rs ^ b;
               6'h27: r = ~(in.rs | b);
               6'h2A: r = ($signed(in.rs) < $signed(b)) ? 32'd1 : 32'd0;
               6'h2B: r = (in.rs < b) ? 32'd1 : 32'd0;
               6'h00: r = b << sh;
               6'h02: r = b >> sh;
               6'h03: r = 32'($signed(b) >>> sh);
               6'h10: r = m_hi;
               6'h12: r = m_lo;
               default: r = 32'd0;
            endcase
         end
      endcase
      o.ctrl   = {in.regwrite, in.memwrite, in.memread, in.memtoreg};
      o.result = r;
      o.wdata  = in.rt;
      o.wreg   = in.regdst ? in.rd_addr : in.rt_addr;
      return o;
   endfunction

   function automatic ex_in_t rand_in();
      ex_in_t in;
      in = ex_in_t'({$urandom, $urandom, $urandom, $urandom});
      return in;
   endfunction

   // One pipeline cycle: drive after a falling edge, check stall, then check EX/MEM at the next falling edge
   task automatic run_cycle(input ex_in_t in, input logic exp_stall, input ex_out_t exp, input string tag);
      ex_out_t e;
      applyStimulus(in);
      #1;
      checkOutput({tag, ".stall"}, {31'd0, stall_o}, {31'd0, exp_stall});
      exp_q.push_back(exp);
      @(negedge clk);
      e = exp_q.pop_front();
      check_ex_mem(tag, e);
   endtask

   task automatic do_mult(input ex_in_t in, input logic [63:0] prod, input string tag);
`ifdef EX_MULT_EN
      for (int i = 0; i < MC + 1; i++) begin
         run_cycle(in, 1'b1, BUBBLE, {tag, ".stall_cyc"});
      end
      run_cycle(in, 1'b0, BUBBLE, {tag, ".drain"});
      m_hi = prod[63:32];
      m_lo = prod[31:0];
`else
      run_cycle(in, 1'b0, model(in), {tag, ".off"});
`endif
   endtask

   initial begin
      ex_in_t       in;
      logic [63:0]  prod_mult;
      logic [63:0]  prod_multu;
      logic [5:0]   fn_list[16];

      fn_list = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                  6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h3F};
`ifdef EX_MULT_EN
      prod_mult  = 64'hFFFF_FFFF_FFFF_FFFA;
      prod_multu = 64'h0000_0002_FFFF_FFFA;
`else
      prod_mult  = 64'd0;
      prod_multu = 64'd0;
`endif

      // Reset held with random inputs, some of them multiplies
      rst_n = 1'b0;
      applyStimulus(rand_in());
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         in = rand_in();
         if (i != 1) begin
            in.aluop     = 2'b10;
            in.imm[5:0]  = 6'h18 | 6'(i & 1);
         end
         applyStimulus(in);
         #1;
         checkOutput("reset.stall", {31'd0, stall_o}, 32'd0);
         check_ex_mem("reset", BUBBLE);
         @(negedge clk);
      end

      // First instruction after release: sub 5-7 -> rd 3
      rst_n = 1'b1;
      run_cycle(rtype(6'h22, 32'd5, 32'd7, 5'd3, 5'd0), 1'b0,
                mk_out(4'b1000, 32'hFFFF_FFFE, 32'd7, 5'd3), "sub");
      run_cycle(rtype(6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd4, 5'd0), 1'b0,
                mk_out(4'b1000, 32'd1, 32'd1, 5'd4), "slt");
      run_cycle(rtype(6'h2B, 32'hFFFF_FFFF, 32'd1, 5'd5, 5'd0), 1'b0,
                mk_out(4'b1000, 32'd0, 32'd1, 5'd5), "sltu");
      run_cycle(rtype(6'h03, 32'd0, 32'h8000_0000, 5'd6, 5'd4), 1'b0,
                mk_out(4'b1000, 32'hF800_0000, 32'h8000_0000, 5'd6), "sra");
      run_cycle(rtype(6'h00, 32'd0, 32'h0000_0003, 5'd7, 5'd31), 1'b0,
                mk_out(4'b1000, 32'h8000_0000, 32'd3, 5'd7), "sll");
      run_cycle(rtype(6'h3F, 32'd9, 32'd9, 5'd8, 5'd0), 1'b0,
                mk_out(4'b1000, 32'd0, 32'd9, 5'd8), "unknown_fn");

      // lw: base 0x1000 + (-4), writes RtAddr
      in = '0;
      in.aluop = 2'b00; in.alusrc = 1'b1; in.regwrite = 1'b1; in.memread = 1'b1; in.memtoreg = 1'b1;
      in.rs = 32'h1000; in.rt = 32'h0000_DEAD; in.imm = 32'hFFFF_FFFC; in.rt_addr = 5'd9; in.rd_addr = 5'd17;
      run_cycle(in, 1'b0, mk_out(4'b1011, 32'h0000_0FFC, 32'h0000_DEAD, 5'd9), "lw");

      // sw: store data forwarded on WriteDataOut
      in = '0;
      in.aluop = 2'b00; in.alusrc = 1'b1; in.memwrite = 1'b1;
      in.rs = 32'h200; in.rt = 32'hCAFE_F00D; in.imm = 32'd8; in.rt_addr = 5'd12; in.rd_addr = 5'd1;
      run_cycle(in, 1'b0, mk_out(4'b0100, 32'h208, 32'hCAFE_F00D, 5'd12), "sw");

      // ori
      in = '0;
      in.aluop = 2'b11; in.alusrc = 1'b1; in.regwrite = 1'b1;
      in.rs = 32'h1200_0000; in.imm = 32'h0000_00F0; in.rt_addr = 5'd2;
      run_cycle(in, 1'b0, mk_out(4'b1000, 32'h1200_00F0, 32'd0, 5'd2), "ori");

      // HI/LO start cleared
      run_cycle(rtype(6'h10, 32'd1, 32'd2, 5'd10, 5'd0), 1'b0, mk_out(4'b1000, 32'd0, 32'd2, 5'd10), "mfhi0");

      // Signed multiply -2 * 3, then read LO and HI straight after
      do_mult(rtype(6'h18, 32'hFFFF_FFFE, 32'd3, 5'd11, 5'd0), prod_mult, "mult");
      run_cycle(rtype(6'h12, 32'd0, 32'd0, 5'd12, 5'd0), 1'b0, mk_out(4'b1000, prod_mult[31:0], 32'd0, 5'd12), "mflo");
      run_cycle(rtype(6'h10, 32'd0, 32'd0, 5'd13, 5'd0), 1'b0, mk_out(4'b1000, prod_mult[63:32], 32'd0, 5'd13), "mfhi");

      // Unsigned multiply of the same operands
      do_mult(rtype(6'h19, 32'hFFFF_FFFE, 32'd3, 5'd14, 5'd0), prod_multu, "multu");
      run_cycle(rtype(6'h10, 32'd0, 32'd0, 5'd15, 5'd0), 1'b0, mk_out(4'b1000, prod_multu[63:32], 32'd0, 5'd15), "mfhi_u");
      run_cycle(rtype(6'h12, 32'd0, 32'd0, 5'd16, 5'd0), 1'b0, mk_out(4'b1000, prod_multu[31:0], 32'd0, 5'd16), "mflo_u");

      // Random non-multiply traffic against the reference model
      for (int i = 0; i < 30; i++) begin
         in = rand_in();
         if (in.aluop == 2'b10) begin
            in.imm[5:0] = fn_list[$urandom_range(15, 0)];
         end
         run_cycle(in, 1'b0, model(in), "rand");
      end

      // Reset during cycle 10 of MUL aborts the multiply and clears HI/LO
      in = rtype(6'h18, 32'hFFFF_FFFE, 32'd3, 5'd11, 5'd0);
`ifdef EX_MULT_EN
      for (int i = 0; i < 10; i++) begin
         run_cycle(in, 1'b1, BUBBLE, "abort.stall_cyc");
      end
`else
      run_cycle(in, 1'b0, model(in), "abort.off");
`endif
      rst_n = 1'b0;
      #1;
      checkOutput("abort.stall", {31'd0, stall_o}, 32'd0);
      check_ex_mem("abort", BUBBLE);
      m_hi = 32'd0;
      m_lo = 32'd0;
      applyStimulus(ex_in_t'('0));
      @(negedge clk);
      rst_n = 1'b1;
      run_cycle(rtype(6'h10, 32'd0, 32'd0, 5'd17, 5'd0), 1'b0, mk_out(4'b1000, 32'd0, 32'd0, 5'd17), "abort.mfhi");
      run_cycle(rtype(6'h12, 32'd0, 32'd0, 5'd18, 5'd0), 1'b0, mk_out(4'b1000, 32'd0, 32'd0, 5'd18), "abort.mflo");

      // Next multiply after the abort runs the full stall
      do_mult(in, prod_mult, "remult");
      run_cycle(rtype(6'h12, 32'd0, 32'd0, 5'd19, 5'd0), 1'b0, mk_out(4'b1000, prod_mult[31:0], 32'd0, 5'd19), "remult.mflo");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
